// File: rtl/level_crossing_gate_sequencer.sv
// Level-crossing barrier sequencer: warning, lower, hold, raise and fault phases with limit-switch supervision.
// Optional audible warning enabled by defining LC_GATE_BUZZER_EN.
module level_crossing_gate_sequencer #(
    parameter int WARN_CYCLES  = 16,
    parameter int MOVE_TIMEOUT = 32,
    parameter int FLASH_DIV    = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       close_req,
    input  logic       gate_down_sw,
    input  logic       gate_up_sw,
    input  logic       fault_clr,
    output logic       motor_down,
    output logic       motor_up,
    output logic       warn_lamp,
    output logic       buzzer,
    output logic       gate_open,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OPEN   = 3'd0,
        S_WARN   = 3'd1,
        S_LOWER  = 3'd2,
        S_CLOSED = 3'd3,
        S_RAISE  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int TIMER_MAX = (WARN_CYCLES > MOVE_TIMEOUT) ? WARN_CYCLES : MOVE_TIMEOUT;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int FLASH_W   = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [TIMER_W-1:0] WARN_LOAD  = TIMER_W'(WARN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] MOVE_LOAD  = TIMER_W'(MOVE_TIMEOUT - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               flash_phase_q, flash_phase_d;

    logic timer_done;
    assign timer_done = (timer_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_OPEN;
            timer_q       <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OPEN:   if (close_req) state_d = S_WARN;
                      else if (gate_down_sw) state_d = S_FAULT;
            S_WARN:   if (!close_req) state_d = S_OPEN;
                      else if (timer_done) state_d = S_LOWER;
            S_LOWER:  if (gate_down_sw) state_d = S_CLOSED;
                      else if (timer_done) state_d = S_FAULT;
            S_CLOSED: if (!close_req) state_d = S_RAISE;
                      else if (!gate_down_sw) state_d = S_FAULT;
            S_RAISE:  if (close_req) state_d = S_LOWER;
                      else if (gate_up_sw) state_d = S_OPEN;
                      else if (timer_done) state_d = S_FAULT;
            S_FAULT:  if (fault_clr && gate_up_sw && !gate_down_sw && !close_req) state_d = S_OPEN;
            default:  state_d = S_FAULT;
        endcase
        // Both limit switches closed is physically impossible: treat as a sensor fault above all else.
        if (state_q != S_FAULT && gate_down_sw && gate_up_sw) state_d = S_FAULT;

        timer_d = timer_q;
        if (state_d != state_q) begin
            case (state_d)
                S_WARN:           timer_d = WARN_LOAD;
                S_LOWER, S_RAISE: timer_d = MOVE_LOAD;
                default:          timer_d = '0;
            endcase
        end else if (!timer_done) begin
            timer_d = timer_q - TIMER_W'(1);
        end

        // Flash restarts only on a fresh warning; RAISE->LOWER keeps the lamp rhythm unbroken.
        flash_cnt_d   = '0;
        flash_phase_d = 1'b0;
        if (state_d == S_WARN && state_q != S_WARN) begin
            flash_phase_d = 1'b1;
        end else if (state_d inside {S_WARN, S_LOWER, S_CLOSED, S_RAISE}) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d   = flash_cnt_q + FLASH_W'(1);
                flash_phase_d = flash_phase_q;
            end
        end
    end

    always_comb begin
        motor_down = 1'b0;
        motor_up   = 1'b0;
        warn_lamp  = 1'b0;
        gate_open  = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_OPEN:   gate_open = 1'b1;
            S_WARN:   warn_lamp = flash_phase_q;
            S_LOWER:  begin motor_down = 1'b1; warn_lamp = flash_phase_q; end
            S_CLOSED: warn_lamp = flash_phase_q;
            S_RAISE:  begin motor_up = 1'b1; warn_lamp = flash_phase_q; end
            default:  begin fault = 1'b1; warn_lamp = 1'b1; end
        endcase
    end

`ifdef LC_GATE_BUZZER_EN
    always_comb begin
        buzzer = 1'b0;
        case (state_q)
            S_WARN, S_LOWER:                     buzzer = flash_phase_q;
            S_OPEN, S_CLOSED, S_RAISE:           buzzer = 1'b0;
            default:                             buzzer = 1'b1;
        endcase
    end
`else
    assign buzzer = 1'b0;
`endif

    assign state = state_q;

endmodule
